// File: rtl/delay_timer_arbiter.sv
// Round-robin owner of one tick-driven interval timer.
// Four requesters each ask for N ticks and get a done pulse.
module delay_timer_arbiter #(
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic [3:0]    req,
  input  logic [4*CW-1:0] delay_in,
  output logic [3:0]    grant,
  output logic [3:0]    done,
  output logic          busy
);

  typedef enum logic [1:0] {
    IDLE,
    COUNT,
    DONE
  } state_t;

  state_t state, state_n;

  logic [3:0]    grant_n, done_n;
  logic          busy_n;
  logic [CW-1:0] count, count_n;
  logic [CW-1:0] dly, dly_n;
  logic [CW-1:0] sel_dly, cnt_inc;
  logic [1:0]    last, last_n;
  logic [1:0]    own, own_n;
  logic [1:0]    win, idx;
  logic          hit;

  // first set request after the last owner, wrapping mod 4
  always_comb begin
    win = '0;
    hit = 1'b0;
    idx = '0;
    for (int k = 1; k <= 4; k++) begin
      idx = last + 2'(k);
      if (!hit && req[idx]) begin
        win = idx;
        hit = 1'b1;
      end
    end
  end

  always_comb begin
    sel_dly = '0;
    for (int i = 0; i < 4; i++) begin
      if (win == 2'(i))
        sel_dly = delay_in[i*CW +: CW];
    end
  end

  assign cnt_inc = count + 1'b1;

  always_comb begin
    state_n = state;
    grant_n = grant;
    done_n  = '0;
    count_n = count;
    dly_n   = dly;
    last_n  = last;
    own_n   = own;
    unique case (state)
      IDLE: begin
        if (hit) begin
          state_n = COUNT;
          grant_n = 4'b0001 << win;
          dly_n   = sel_dly;
          count_n = '0;
          own_n   = win;
        end
      end
      COUNT: begin
        // abort outranks a coincident final tick
        if ((req & grant) == 4'b0000) begin
          state_n = IDLE;
          grant_n = '0;
          last_n  = own;
        end else if (dly == '0) begin
          state_n = DONE;
          done_n  = grant;
        end else if (tick) begin
          count_n = cnt_inc;
          if (cnt_inc == dly) begin
            state_n = DONE;
            done_n  = grant;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        grant_n = '0;
        last_n  = own;
      end
      default: begin
        state_n = IDLE;
        grant_n = '0;
      end
    endcase
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      grant <= '0;
      done  <= '0;
      busy  <= 1'b0;
      count <= '0;
      dly   <= '0;
      last  <= 2'd3;
      own   <= '0;
    end else begin
      state <= state_n;
      grant <= grant_n;
      done  <= done_n;
      busy  <= busy_n;
      count <= count_n;
      dly   <= dly_n;
      last  <= last_n;
      own   <= own_n;
    end
  end

endmodule
